cmm_bsc_sfifo_rdp: RTL and testbench
====================================

CMM_BSC_SFIFO_RDP -- requirements
Module: cmm_bsc_sfifo_rdp

Purpose: read-side prefetch engine for the synchronous FIFO controller plus its RAM. Drives the FIFO read port (re, rempty, RAM read data) and presents a first-word-fall-through valid/ready stream.

Interface
REQ-001 The block SHALL have parameter C_DW, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter C_RL, default 1, meaning RAM read latency in cycles; legal values are 1 and 2 only.
REQ-003 The block SHALL use a derived localparam C_BD = C_RL+1, meaning the internal output buffer depth.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port rempty, input, width 1: FIFO empty flag from the FIFO controller.
REQ-007 The block SHALL have port re, output, width 1: FIFO read enable.
REQ-008 The block SHALL have port rdata, input, width C_DW: RAM read data, valid C_RL cycles after the re cycle.
REQ-009 The block SHALL have port flush, input, width 1: discard all prefetched and in-flight data.
REQ-010 The block SHALL have port m_valid, output, width 1: stream data valid.
REQ-011 The block SHALL have port m_ready, input, width 1: stream consumer ready.
REQ-012 The block SHALL have port m_data, output, width C_DW: stream data.
REQ-013 The block SHALL have port m_cnt, output, width 2: number of beats currently in the buffer.
REQ-014 The block SHALL have port pop_cnt, output, width 16: count of accepted beats (see Configuration).

Function
REQ-015 The block SHALL define a transfer as m_valid&m_ready at a rising edge.
REQ-016 The block SHALL track occupancy O = buffered beats + reads in flight; O SHALL never exceed C_BD.
REQ-017 The block SHALL drive re = !rempty & !flush & (O<C_BD | transfer), combinationally.
REQ-018 The block SHALL capture rdata into the buffer tail exactly C_RL cycles after each re=1 cycle, unless that read is marked discarded.
REQ-019 The block SHALL register m_valid, equal to (m_cnt!=0).
REQ-020 The block SHALL drive m_data from the buffer head; m_data SHALL hold stable while m_valid&!m_ready.
REQ-021 The block SHALL produce m_valid C_RL+1 cycles after the first re following rempty falling; this is the latency.
REQ-022 With m_ready held at 1 and rempty at 0, the block SHALL transfer one beat per cycle with no bubbles.
REQ-023 The block SHALL output beats in the exact order they were read; no beat is duplicated or lost except by flush.
REQ-024 When a capture and a transfer occur in the same cycle, m_cnt SHALL be unchanged and the order SHALL be preserved.
REQ-025 In a cycle with flush=1, a transfer that occurs still counts as completed; re SHALL be 0.
REQ-026 At the end of a flush cycle, m_cnt SHALL become 0 and m_valid SHALL become 0.
REQ-027 Reads in flight at a flush SHALL be dropped on return and not captured; re SHALL resume the cycle after flush deasserts, even while drops are pending.
REQ-028 A flush asserted for multiple consecutive cycles SHALL hold re=0 throughout.
REQ-029 The buffer pointers SHALL wrap modulo C_BD.

Reset
REQ-030 While rst_n=1 at a rising edge, the block SHALL reset: re=0, m_valid=0, m_cnt=0, m_data=0, pop_cnt=0, in-flight count 0, drop marks cleared.
REQ-031 Reset SHALL take priority over flush and over transfers.
REQ-032 Reads in flight when reset is applied SHALL be discarded.
REQ-033 While rst_n=1, re SHALL be forced to 0.

Configuration
REQ-034 With macro CMM_BSC_SFIFO_RDP_PCNT_EN defined, pop_cnt SHALL increment by 1 per transfer, wrap 0xFFFF->0x0000, and is not cleared by flush.
REQ-035 Without CMM_BSC_SFIFO_RDP_PCNT_EN, the pop_cnt port SHALL remain present, tied to 0, with no counter logic.

Verification
REQ-036 C_RL=1, FIFO holds 0x11,0x22,0x33, m_ready=1 -> re high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles; first m_valid 2 cycles after the first re.
REQ-037 C_RL=2, m_ready=0, FIFO holds 5 words -> exactly 3 re pulses; m_cnt=3; m_data=first word stable; on m_ready=1 all 5 arrive in order, one per cycle after the refill latency.
REQ-038 C_RL=2, flush asserted with 2 reads in flight and m_cnt=1 -> next cycle m_valid=0, m_cnt=0; both returning words dropped; next FIFO word is the first beat emitted.
REQ-039 Random m_ready at 50%, 1000 random words through FIFO -> scoreboard in-order match, no loss, O<=C_BD always; pop_cnt=1000 with macro defined, 0 without.
REQ-040 Reset asserted mid-stream with m_cnt=2 and 1 read in flight -> after reset re=0, m_valid=0, m_cnt=0; the in-flight word is never emitted.
REQ-041 pop_cnt preloaded via 65536 transfers (macro defined) -> pop_cnt wraps to 0x0000.

Source files
------------

// File: rtl/cmm_bsc_sfifo_rdp.sv
// cmm_bsc_sfifo_rdp: FWFT read prefetch for a sync FIFO + RAM; pop_cnt counter enabled by CMM_BSC_SFIFO_RDP_PCNT_EN
module cmm_bsc_sfifo_rdp #(
  parameter int C_DW = 32,
  parameter int C_RL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rempty,
  output logic            re,
  input  logic [C_DW-1:0] rdata,
  input  logic            flush,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [C_DW-1:0] m_data,
  output logic [1:0]      m_cnt,
  output logic [15:0]     pop_cnt
);
  localparam int C_BD = C_RL + 1;
  localparam int C_AW = $clog2(C_BD);
  logic [C_DW-1:0] mem_q [C_BD];
  logic [C_DW-1:0] mem_d [C_BD];
  logic [C_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [1:0]      cnt_q, cnt_d, infl;
  logic [C_RL-1:0] rd_q, rd_d;
  logic            m_valid_q, m_valid_d, xfer, cap;
  logic [2:0]      occ;
  function automatic logic [C_AW-1:0] inc(input logic [C_AW-1:0] p);
    return p == C_AW'(C_BD - 1) ? '0 : p + 1'b1;
  endfunction
  // rd_q is a shift line of outstanding reads; clearing it on flush drops returning words
  always_comb begin
    xfer = m_valid_q & m_ready;
    infl = '0;
    for (int i = 0; i < C_RL; i++) infl = infl + 2'(rd_q[i]);
    occ = 3'(cnt_q) + 3'(infl);
    re = !rst_n && !rempty && !flush && (occ < 3'(C_BD) || xfer);
    cap = rd_q[C_RL-1] && !flush;
    rd_d = flush ? '0 : C_RL'({rd_q, re});
    cnt_d = flush ? '0 : cnt_q + 2'(cap) - 2'(xfer);
    wp_d = cap ? inc(wp_q) : wp_q;
    rp_d = flush ? wp_q : xfer ? inc(rp_q) : rp_q;
    mem_d = mem_q;
    if (cap) mem_d[wp_q] = rdata;
    m_valid_d = cnt_d != '0;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_q     <= '{default: '0};
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      m_valid_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      m_valid_q <= m_valid_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_data  = mem_q[rp_q];
  assign m_cnt   = cnt_q;
`ifdef CMM_BSC_SFIFO_RDP_PCNT_EN
  logic [15:0] pop_q, pop_d;
  assign pop_d = pop_q + 16'(xfer);
  always_ff @(posedge clk) pop_q <= rst_n ? '0 : pop_d;
  assign pop_cnt = pop_q;
`else
  assign pop_cnt = '0;
`endif
endmodule

// File: tb/tb_cmm_bsc_sfifo_rdp.sv
// tb_cmm_bsc_sfifo_rdp: directed checks of the prefetch engine at read latency 1 and 2
module tb_cmm_bsc_sfifo_rdp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic [1:0]  re_w, rempty_w, mv_w;
  logic [31:0] rd_w [2];
  logic [31:0] md_w [2];
  logic [1:0]  mc_w [2];
  logic [15:0] pc_w [2];
  logic [31:0] fmem [2][2048];
  logic [31:0] p1 [2];
  logic [31:0] p2 [2];
  int          wp [2] = '{0, 0};
  int          rp [2] = '{0, 0};
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gi
    cmm_bsc_sfifo_rdp #(.C_DW(32), .C_RL(g + 1)) u_dut (
      .clk(clk), .rst_n(rst), .rempty(rempty_w[g]), .re(re_w[g]), .rdata(rd_w[g]),
      .flush(flush), .m_valid(mv_w[g]), .m_ready(m_ready), .m_data(md_w[g]),
      .m_cnt(mc_w[g]), .pop_cnt(pc_w[g]));
  end
  assign rempty_w[0] = wp[0] == rp[0];
  assign rempty_w[1] = wp[1] == rp[1];
  assign rd_w[0] = p1[0];
  assign rd_w[1] = p2[1];
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (re_w[k]) begin
        p1[k] <= fmem[k][rp[k] % 2048];
        rp[k] <= rp[k] + 1;
      end
      p2[k] <= p1[k];
    end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int k, input logic [31:0] w);
    fmem[k][wp[k] % 2048] = w;
    wp[k]++;
  endtask
  task automatic wait_mv(input int k, input string tag);
    int c = 0;
    while (!mv_w[k] && c < 12) begin
      tick();
      #1;
      c++;
    end
    chk(tag, 32'(mv_w[k]), 32'd1);
  endtask
  task automatic drain();
    m_ready = 1'b1;
    repeat (8) tick();
  endtask
  logic [31:0] ew [1000];
  logic [31:0] exp_a [6];
  logic [5:0]  re_a, mv_a;
  int n, xc [2], rc [2], cyc;
  initial begin
    repeat (3) tick();
    #1;
    chk("rst_re", 32'(re_w[1]), 0);
    chk("rst_mv", 32'(mv_w[1]), 0);
    chk("rst_cnt", 32'(mc_w[1]), 0);
    chk("rst_data", md_w[1], 0);
    chk("rst_pcnt", 32'(pc_w[1]), 0);
    // latency 1: three words stream back-to-back
    push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
    m_ready = 1'b1;
    re_a = 6'b000111; mv_a = 6'b011100;
    exp_a = '{0, 0, 32'h11, 32'h22, 32'h33, 0};
    tick();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        tick();
        #1;
      end
      chk($sformatf("a_re%0d", c), 32'(re_w[0]), 32'(re_a[c]));
      chk($sformatf("a_mv%0d", c), 32'(mv_w[0]), 32'(mv_a[c]));
      if (mv_a[c]) chk($sformatf("a_data%0d", c), md_w[0], exp_a[c]);
    end
    // latency 2, consumer stalled: buffer fills to three
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1, 32'hA1 + i);
    #1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      n += int'(re_w[1]);
      tick();
      #1;
    end
    chk("b_re_pulses", n, 3);
    chk("b_cnt", 32'(mc_w[1]), 3);
    chk("b_head", md_w[1], 32'hA1);
    m_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        tick();
        #1;
      end
      chk($sformatf("b_mv%0d", c), 32'(mv_w[1]), 1);
      chk($sformatf("b_data%0d", c), md_w[1], 32'hA1 + c);
    end
    tick();
    #1;
    chk("b_empty", 32'(mv_w[1]), 0);
    // flush with one beat buffered and two reads in flight
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1, 32'hB1 + i);
    repeat (3) tick();
    flush = 1'b1;
    #1;
    chk("c_pre_cnt", 32'(mc_w[1]), 1);
    chk("c_flush_re", 32'(re_w[1]), 0);
    tick();
    flush = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("c_post_mv", 32'(mv_w[1]), 0);
    chk("c_post_cnt", 32'(mc_w[1]), 0);
    chk("c_resume_re", 32'(re_w[1]), 1);
    wait_mv(1, "c_wait");
    chk("c_first", md_w[1], 32'hB4);
    drain();
    // reset with two buffered beats and one read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1, 32'hC1 + i);
    repeat (4) tick();
    #1;
    chk("d_pre_cnt", 32'(mc_w[1]), 2);
    rst = 1'b1;
    #1;
    chk("d_rst_re", 32'(re_w[1]), 0);
    tick();
    #1;
    chk("d_rst_mv", 32'(mv_w[1]), 0);
    chk("d_rst_cnt", 32'(mc_w[1]), 0);
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    wait_mv(1, "d_wait");
    chk("d_first", md_w[1], 32'hC4);
    drain();
    // random backpressure, both latencies, scoreboarded
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ew[i] = $urandom;
      push(0, ew[i]);
      push(1, ew[i]);
    end
    xc = '{0, 0};
    rc = '{0, 0};
    cyc = 0;
    while ((xc[0] < 1000 || xc[1] < 1000) && cyc < 6000) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("e_occ%0d", k), 32'(rc[k] - xc[k] <= k + 2), 1);
        if (re_w[k]) rc[k]++;
        if (mv_w[k] && m_ready) begin
          chk($sformatf("e_data%0d_%0d", k, xc[k]), md_w[k], xc[k] < 1000 ? ew[xc[k]] : 32'hDEAD);
          xc[k]++;
        end
      end
      cyc++;
    end
    chk("e_count0", xc[0], 1000);
    chk("e_count1", xc[1], 1000);
    tick();
    tick();
`ifdef CMM_BSC_SFIFO_RDP_PCNT_EN
    chk("e_pcnt0", 32'(pc_w[0]), 1000);
    chk("e_pcnt1", 32'(pc_w[1]), 1000);
    m_ready = 1'b1;
    wp[1] = wp[1] + 64536;
    cyc = 0;
    while ((!rempty_w[1] || mv_w[1]) && cyc < 66000) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
    chk("f_wrap", 32'(pc_w[1]), 0);
`else
    chk("e_pcnt0", 32'(pc_w[0]), 0);
    chk("e_pcnt1", 32'(pc_w[1]), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
